// File: rtl/uart_echo_buffered_if.sv
// rtl/uart_echo_buffered_if.sv - pin bundle of the buffered UART echo block
// Purpose: groups the board-facing and status signals of uart_echo_buffered.
// Ports:
//   rx, echo_en          board inputs (serial in, echo-enable button)
//   tx, led              board outputs (serial out, active-low LEDs)
//   rx_data, rx_valid    last good received word and its one-clk strobe
//   frame_err            one-clk strobe on a rejected frame
//   overflow, fifo_count sticky drop flag and TX FIFO occupancy
// Modports: slave = design side, master = board / stimulus side.
interface uart_echo_buffered_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LED_BITS   = 4
);
  logic                        rx;
  logic                        echo_en;
  logic                        tx;
  logic [LED_BITS-1:0]         led;
  logic [DATA_BITS-1:0]        rx_data;
  logic                        rx_valid;
  logic                        frame_err;
  logic                        overflow;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  modport slave (
    input  rx, echo_en,
    output tx, led, rx_data, rx_valid, frame_err, overflow, fifo_count
  );

  modport master (
    output rx, echo_en,
    input  tx, led, rx_data, rx_valid, frame_err, overflow, fifo_count
  );
endinterface

// File: rtl/uart_echo_buffered.sv
// rtl/uart_echo_buffered.sv - UART receiver, TX FIFO and transmitter that echoes received words
// Purpose: 16x oversampled UART RX; good words update rx_data/led and, while
//   echo_en is high, are queued in a TX FIFO that a UART TX drains onto tx.
// Ports:
//   clk   system clock
//   rst   asynchronous active-low reset
//   bus   uart_echo_buffered_if.slave (rx, echo_en, tx, led, rx_data,
//         rx_valid, frame_err, overflow, fifo_count)
// Build option: define UART_PARITY_EN for one even-parity bit after the data
//   bits in both directions; undefined gives plain N1 framing.
module uart_echo_buffered #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LED_BITS   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_echo_buffered_if.slave  bus
);
  localparam int DIV = CLK_HZ / (BAUD * 16);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int BW  = $clog2(DATA_BITS);

  // ---------------- oversample tick, shared by RX and TX ----------------
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          tx_tick;

  assign tick    = (tick_cnt == TW'(DIV - 1));
  assign tx_tick = tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // ---------------- rx synchroniser (idle-high reset) ----------------
  logic rx_meta, rxs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rxs     <= rx_meta;
    end
  end

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

  rx_state_t            rx_state, rx_state_n;
  logic [3:0]           rx_tcnt, rx_tcnt_n;
  logic [BW-1:0]        rx_bcnt, rx_bcnt_n;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
  logic [DATA_BITS-1:0] rx_data_r, rx_data_n;
  logic [LED_BITS-1:0]  led_r, led_n;
  logic                 rx_valid_r, rx_valid_n;
  logic                 frame_err_r, frame_err_n;
  logic                 rx_good;
`ifdef UART_PARITY_EN
  logic                 rx_par_ok, rx_par_ok_n;
  assign rx_good = rxs & rx_par_ok;
`else
  assign rx_good = rxs;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state    <= RX_IDLE;
      rx_tcnt     <= '0;
      rx_bcnt     <= '0;
      rx_shift    <= '0;
      rx_data_r   <= '0;
      led_r       <= '1;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_ok   <= 1'b0;
`endif
    end else begin
      rx_state    <= rx_state_n;
      rx_tcnt     <= rx_tcnt_n;
      rx_bcnt     <= rx_bcnt_n;
      rx_shift    <= rx_shift_n;
      rx_data_r   <= rx_data_n;
      led_r       <= led_n;
      rx_valid_r  <= rx_valid_n;
      frame_err_r <= frame_err_n;
`ifdef UART_PARITY_EN
      rx_par_ok   <= rx_par_ok_n;
`endif
    end
  end

  // Bit counters are 4-bit tick counters that wrap 15 -> 0 on their own.
  always_comb begin
    rx_state_n  = rx_state;
    rx_tcnt_n   = rx_tcnt;
    rx_bcnt_n   = rx_bcnt;
    rx_shift_n  = rx_shift;
    rx_data_n   = rx_data_r;
    led_n       = led_r;
    rx_valid_n  = 1'b0;
    frame_err_n = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_ok_n = rx_par_ok;
`endif
    case (rx_state)
      RX_IDLE: begin
        if (!rxs) begin
          rx_state_n = RX_START;
          rx_tcnt_n  = '0;
        end
      end
      RX_START: begin
        // Half a bit in: still low means a real start, else a glitch.
        if (tick) begin
          if (rx_tcnt == 4'd7) begin
            rx_tcnt_n  = '0;
            rx_bcnt_n  = '0;
            rx_state_n = rxs ? RX_IDLE : RX_DATA;
          end else begin
            rx_tcnt_n = rx_tcnt + 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          rx_tcnt_n = rx_tcnt + 1'b1;
          if (rx_tcnt == 4'd15) begin
            rx_shift_n = {rxs, rx_shift[DATA_BITS-1:1]};
            if (rx_bcnt == BW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
              rx_state_n = RX_PARITY;
`else
              rx_state_n = RX_STOP;
`endif
            end else begin
              rx_bcnt_n = rx_bcnt + 1'b1;
            end
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (tick) begin
          rx_tcnt_n = rx_tcnt + 1'b1;
          if (rx_tcnt == 4'd15) begin
            rx_par_ok_n = (rxs == ^rx_shift);
            rx_state_n  = RX_STOP;
          end
        end
      end
`endif
      RX_STOP: begin
        // Leave at mid-stop so a following start edge is not missed.
        if (tick) begin
          rx_tcnt_n = rx_tcnt + 1'b1;
          if (rx_tcnt == 4'd15) begin
            rx_state_n = RX_IDLE;
            if (rx_good) begin
              rx_data_n  = rx_shift;
              led_n      = ~rx_shift[LED_BITS-1:0];
              rx_valid_n = 1'b1;
            end else begin
              frame_err_n = 1'b1;
            end
          end
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 overflow_r;
  logic                 push, pop, full, push_ok;

  assign push    = rx_valid_r & bus.echo_en;
  assign full    = (count == CW'(FIFO_DEPTH));
  // A pop in the same clk frees the slot, so a push while full still lands.
  assign push_ok = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rx_data_r;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
      if (push && full && !pop) overflow_r <= 1'b1;
    end
  end

  // ---------------- transmitter ----------------
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  tx_state_t            tx_state, tx_state_n;
  logic [3:0]           tx_tcnt, tx_tcnt_n;
  logic [BW-1:0]        tx_bcnt, tx_bcnt_n;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
  logic                 tx_r, tx_n;
`ifdef UART_PARITY_EN
  logic                 tx_par, tx_par_n;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_tcnt  <= '0;
      tx_bcnt  <= '0;
      tx_shift <= '0;
      tx_r     <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      tx_state <= tx_state_n;
      tx_tcnt  <= tx_tcnt_n;
      tx_bcnt  <= tx_bcnt_n;
      tx_shift <= tx_shift_n;
      tx_r     <= tx_n;
`ifdef UART_PARITY_EN
      tx_par   <= tx_par_n;
`endif
    end
  end

  // tx is registered from the next state so the line changes with the state.
  always_comb begin
    tx_state_n = tx_state;
    tx_tcnt_n  = tx_tcnt;
    tx_bcnt_n  = tx_bcnt;
    tx_shift_n = tx_shift;
    pop        = 1'b0;
`ifdef UART_PARITY_EN
    tx_par_n   = tx_par;
`endif
    case (tx_state)
      TX_IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          tx_shift_n = mem[rd_ptr];
          tx_tcnt_n  = '0;
          tx_bcnt_n  = '0;
          tx_state_n = TX_START;
`ifdef UART_PARITY_EN
          tx_par_n   = ^mem[rd_ptr];
`endif
        end
      end
      TX_START: begin
        if (tx_tick) begin
          tx_tcnt_n = tx_tcnt + 1'b1;
          if (tx_tcnt == 4'd15) tx_state_n = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          tx_tcnt_n = tx_tcnt + 1'b1;
          if (tx_tcnt == 4'd15) begin
            tx_shift_n = {1'b0, tx_shift[DATA_BITS-1:1]};
            if (tx_bcnt == BW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
              tx_state_n = TX_PARITY;
`else
              tx_state_n = TX_STOP;
`endif
            end else begin
              tx_bcnt_n = tx_bcnt + 1'b1;
            end
          end
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        if (tx_tick) begin
          tx_tcnt_n = tx_tcnt + 1'b1;
          if (tx_tcnt == 4'd15) tx_state_n = TX_STOP;
        end
      end
`endif
      TX_STOP: begin
        if (tx_tick) begin
          tx_tcnt_n = tx_tcnt + 1'b1;
          if (tx_tcnt == 4'd15) tx_state_n = TX_IDLE;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase

    case (tx_state_n)
      TX_START:  tx_n = 1'b0;
      TX_DATA:   tx_n = tx_shift_n[0];
`ifdef UART_PARITY_EN
      TX_PARITY: tx_n = tx_par_n;
`endif
      default:   tx_n = 1'b1;
    endcase
  end

  // ---------------- outputs ----------------
  assign bus.tx         = tx_r;
  assign bus.led        = led_r;
  assign bus.rx_data    = rx_data_r;
  assign bus.rx_valid   = rx_valid_r;
  assign bus.frame_err  = frame_err_r;
  assign bus.overflow   = overflow_r;
  assign bus.fifo_count = count;
endmodule
